// File: rtl/alarm_controller.sv
// Alarm sequencing FSM driving the buzzer enable (ring / snooze / silence / disarm).
// Optional macro ALARM_SNOOZE_LIMIT_EN caps honoured snoozes per alarm event at MAX_SNOOZES.
module alarm_controller #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_SEC     = 300
`ifdef ALARM_SNOOZE_LIMIT_EN
  ,
  parameter int MAX_SNOOZES    = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] al_hr,
  input  logic [5:0] al_min,
  input  logic       armed,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer_en,
  output logic       snoozing,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RINGING  = 2'd1;
  localparam logic [1:0] S_SNOOZED  = 2'd2;
  localparam logic [1:0] S_SILENCED = 2'd3;

  localparam int RW = $clog2(RING_TIMEOUT_S) + 1;
  localparam int SW = $clog2(SNOOZE_SEC) + 1;

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT_S - 1);
  localparam logic [RW-1:0] RING_MAX    = '1;
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ringCnt_q, ringCnt_d;
  logic [SW-1:0] snoozeCnt_q, snoozeCnt_d;
  logic          buzzerEn_q, buzzerEn_d;
  logic          snoozing_q, snoozing_d;
  logic          hmEq, match, snoozeLimitHit;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int NW = $clog2(MAX_SNOOZES) + 1;
  logic [NW-1:0] snoozeNum_q, snoozeNum_d;
  assign snoozeLimitHit = (snoozeNum_q == NW'(MAX_SNOOZES));
`else
  assign snoozeLimitHit = 1'b0;
`endif

  assign hmEq  = (cur_hr == al_hr) && (cur_min == al_min);
  assign match = armed && hmEq && (cur_sec == 6'd0);

  // Events are resolved as: disarm > dismiss > snooze > tick-driven timeout/expiry.
  always_comb begin
    state_d     = state_q;
    ringCnt_d   = ringCnt_q;
    snoozeCnt_d = snoozeCnt_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
    snoozeNum_d = snoozeNum_q;
`endif
    if (!armed) begin
      state_d     = S_IDLE;
      ringCnt_d   = '0;
      snoozeCnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snoozeNum_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (match) begin
            state_d   = S_RINGING;
            ringCnt_d = '0;
          end
        end
        S_RINGING: begin
          if (dismiss) begin
            state_d = S_SILENCED;
          end else if (snooze) begin
            if (snoozeLimitHit) begin
              state_d = S_SILENCED;
            end else begin
              state_d     = S_SNOOZED;
              snoozeCnt_d = SNOOZE_LOAD;
              ringCnt_d   = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
              snoozeNum_d = snoozeNum_q + NW'(1);
`endif
            end
          end else if (tick_1hz) begin
            if (ringCnt_q != RING_MAX) ringCnt_d = ringCnt_q + RW'(1);
            if (ringCnt_q == RING_LAST) state_d = S_SILENCED;
          end
        end
        S_SNOOZED: begin
          if (dismiss) begin
            state_d = S_SILENCED;
          end else if (tick_1hz) begin
            if (snoozeCnt_q != '0) snoozeCnt_d = snoozeCnt_q - SW'(1);
            if (snoozeCnt_q == SW'(1)) begin
              state_d   = S_RINGING;
              ringCnt_d = '0;
            end
          end
        end
        default: begin
          // Stay silent for the rest of the alarm minute so the same HH:MM cannot retrigger.
          if (!hmEq) begin
            state_d     = S_IDLE;
            ringCnt_d   = '0;
            snoozeCnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snoozeNum_d = '0;
`endif
          end
        end
      endcase
    end
    buzzerEn_d = (state_d == S_RINGING);
    snoozing_d = (state_d == S_SNOOZED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ringCnt_q   <= '0;
      snoozeCnt_q <= '0;
      buzzerEn_q  <= 1'b0;
      snoozing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ringCnt_q   <= ringCnt_d;
      snoozeCnt_q <= snoozeCnt_d;
      buzzerEn_q  <= buzzerEn_d;
      snoozing_q  <= snoozing_d;
    end
  end

`ifdef ALARM_SNOOZE_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) snoozeNum_q <= '0;
    else     snoozeNum_q <= snoozeNum_d;
  end
`endif

  assign buzzer_en = buzzerEn_q;
  assign snoozing  = snoozing_q;
  assign state     = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an event-level reference model.
module tb_alarm_controller;

  localparam int RT = 5;
  localparam int SS = 3;
  localparam int MS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] al_hr;
  logic [5:0] al_min;
  logic       armed;
  logic       snooze;
  logic       dismiss;
  logic       buzzer_en;
  logic       snoozing;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  typedef enum int {M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_SILENT = 3} modeT;
  modeT mMode = M_IDLE;
  int   mRingSecs = 0;
  int   mSnoozeLeft = 0;
  int   mSnoozesUsed = 0;

  alarm_controller #(
    .RING_TIMEOUT_S(RT),
    .SNOOZE_SEC    (SS)
`ifdef ALARM_SNOOZE_LIMIT_EN
    ,
    .MAX_SNOOZES   (MS)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .cur_hr   (cur_hr),
    .cur_min  (cur_min),
    .cur_sec  (cur_sec),
    .al_hr    (al_hr),
    .al_min   (al_min),
    .armed    (armed),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .buzzer_en(buzzer_en),
    .snoozing (snoozing),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic bit limitReached();
`ifdef ALARM_SNOOZE_LIMIT_EN
    return mSnoozesUsed >= MS;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: one alarm event at a time, tracked as elapsed ring seconds and
  // remaining snooze seconds; the resulting mode is what the outputs show next cycle.
  task automatic modelStep();
    bit hmEq;
    hmEq = (cur_hr == al_hr) && (cur_min == al_min);
    if (rst || !armed) begin
      mMode = M_IDLE;
      mRingSecs = 0;
      mSnoozeLeft = 0;
      mSnoozesUsed = 0;
    end else if (mMode == M_IDLE) begin
      if (hmEq && cur_sec == 6'd0) begin
        mMode = M_RING;
        mRingSecs = 0;
      end
    end else if (mMode == M_SILENT) begin
      if (!hmEq) begin
        mMode = M_IDLE;
        mSnoozesUsed = 0;
      end
    end else if (dismiss) begin
      mMode = M_SILENT;
    end else if (mMode == M_RING && snooze) begin
      if (limitReached()) begin
        mMode = M_SILENT;
      end else begin
        mMode = M_SNOOZE;
        mSnoozeLeft = SS;
        mSnoozesUsed++;
      end
    end else if (tick_1hz) begin
      if (mMode == M_RING) begin
        mRingSecs++;
        if (mRingSecs >= RT) mMode = M_SILENT;
      end else begin
        mSnoozeLeft--;
        if (mSnoozeLeft <= 0) begin
          mMode = M_RING;
          mRingSecs = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep();
    #2;
    if (chkEn) begin
      logic [1:0] expState;
      logic       expBuzz, expSnz;
      expState = 2'(int'(mMode));
      expBuzz  = (mMode == M_RING);
      expSnz   = (mMode == M_SNOOZE);
      checks++;
      if (state !== expState || buzzer_en !== expBuzz || snoozing !== expSnz) begin
        errors++;
        $display("[TB] FAIL model t=%0t got state=%0d buzz=%b snz=%b expected state=%0d buzz=%b snz=%b",
                 $time, state, buzzer_en, snoozing, expState, expBuzz, expSnz);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] expState,
                             input logic expBuzz, input logic expSnz);
    checks++;
    if (state !== expState || buzzer_en !== expBuzz || snoozing !== expSnz) begin
      errors++;
      $display("[TB] FAIL %s got state=%0d buzz=%b snz=%b expected state=%0d buzz=%b snz=%b",
               name, state, buzzer_en, snoozing, expState, expBuzz, expSnz);
    end
  endtask

  task automatic advanceTime();
    if (cur_sec == 6'd59) begin
      cur_sec = 6'd0;
      if (cur_min == 6'd59) begin
        cur_min = 6'd0;
        cur_hr  = (cur_hr == 5'd23) ? 5'd0 : cur_hr + 5'd1;
      end else begin
        cur_min = cur_min + 6'd1;
      end
    end else begin
      cur_sec = cur_sec + 6'd1;
    end
  endtask

  task automatic setTime(input int h, input int m, input int s);
    cur_hr  = 5'(h);
    cur_min = 6'(m);
    cur_sec = 6'(s);
  endtask

  // One clock cycle of stimulus, driven from a negedge and ending on the next negedge.
  task automatic applyStimulus(input bit doTick, input bit doSnooze, input bit doDismiss);
    tick_1hz = doTick;
    snooze   = doSnooze;
    dismiss  = doDismiss;
    if (doTick) advanceTime();
    @(negedge clk);
    tick_1hz = 1'b0;
    snooze   = 1'b0;
    dismiss  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    armed = 1'b1; al_hr = 5'd7; al_min = 6'd30;
    setTime(7, 29, 58);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chkEn = 1'b1;
    checkOutput("reset", 2'd0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_before_match", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_ring", 2'd1, 1'b1, 1'b0);

    ticks(4);
    checkOutput("t2_four_ticks", 2'd1, 1'b1, 1'b0);
    ticks(1);
    checkOutput("t2_timeout", 2'd3, 1'b0, 1'b0);
    setTime(7, 30, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2_no_retrigger", 2'd3, 1'b0, 1'b0);
    setTime(7, 31, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t2_idle", 2'd0, 1'b0, 1'b0);

    setTime(7, 29, 59);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t3_ring", 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_snooze", 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(2);
    checkOutput("t3_snooze_hold", 2'd2, 1'b0, 1'b1);
    ticks(1);
    checkOutput("t3_resume", 2'd1, 1'b1, 1'b0);
    ticks(4);
    checkOutput("t3_ring_restart", 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_dismiss", 2'd3, 1'b0, 1'b0);

    setTime(7, 31, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setTime(7, 30, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("t4_dismiss_wins", 2'd3, 1'b0, 1'b0);
    setTime(7, 31, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setTime(7, 30, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    armed = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_disarm", 2'd0, 1'b0, 1'b0);
    armed = 1'b1;
    setTime(7, 30, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    ticks(4);
    checkOutput("t4_rearm_ring", 2'd1, 1'b1, 1'b0);
    ticks(1);
    checkOutput("t4_rearm_timeout", 2'd3, 1'b0, 1'b0);

    setTime(7, 31, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setTime(7, 30, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t5_reset", 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_retrigger", 2'd1, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t6_second_snooze", 2'd2, 1'b0, 1'b1);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef ALARM_SNOOZE_LIMIT_EN
    checkOutput("t6_third_snooze", 2'd3, 1'b0, 1'b0);
`else
    checkOutput("t6_third_snooze", 2'd2, 1'b0, 1'b1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 3))
          0: setTime(7, 29, 55 + $urandom_range(0, 4));
          1: setTime(7, 30, 0);
          2: setTime(7, 31, $urandom_range(0, 59));
          default: setTime($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        endcase
      end
      if ($urandom_range(0, 999) == 0) al_min = ($urandom_range(0, 1) == 0) ? 6'd30 : 6'd31;
      if ($urandom_range(0, 299) == 0) armed = ~armed;
      if (!armed && $urandom_range(0, 19) == 0) armed = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 59) == 0);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
